// File: rtl/ram_dp_init.sv
// ram_dp_init
// Simple-dual-port synchronous RAM (one write port, one read port, one clock)
// with byte-lane write enables, a registered read carrying a valid flag, a
// selectable read-during-write policy and a hardware clear sweep that writes
// INIT_VALUE to every word after each reset.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   write_enable   write request (ignored while busy)
//   write_address  write address
//   data_in        write data
//   byte_enable    per-byte write mask; bit i gates data_in[8i+7:8i]
//   read_enable    read request (ignored while busy)
//   read_address   read address
//   data_out       registered read data; holds its value between reads
//   read_valid     one-cycle pulse when data_out carries new read data
//   busy           high while the init sweep runs
//   dbg_state      FSM state for observation (0 = INIT, 1 = READY)
//
// Handshake: there is no backpressure. A read is accepted on every rising
// edge where read_enable = 1 and busy = 0; data_out and read_valid = 1 appear
// one edge later. A write is accepted on every rising edge where
// write_enable = 1 and busy = 0. Requests made while busy are dropped.
module ram_dp_init #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 2,
    parameter int unsigned           RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    input  logic                    read_enable,
    input  logic [ADDR_WIDTH-1:0]   read_address,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    read_valid,
    output logic                    busy,
    output logic                    dbg_state
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LANES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    read_valid_q, read_valid_d;

    // Storage is deliberately not reset; the sweep clears it.
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH-1:0]   wr_merged;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Merged write word: enabled lanes from data_in, the rest from the
    // current contents. A zero mask therefore rewrites the old word.
    always_comb begin
        wr_merged = mem[write_address];
        for (int i = 0; i < LANES; i++) begin
            if (byte_enable[i]) begin
                wr_merged[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Read source. The array read is always the pre-write word (read-first);
    // write-first mode forwards the merged word on a same-address collision.
    always_comb begin
        rd_word = mem[read_address];
        if ((RDW_MODE == 1) && write_enable && (write_address == read_address)) begin
            rd_word = wr_merged;
        end
    end

    // Next-state, sweep and port control.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        read_valid_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = write_address;
        mem_wdata    = wr_merged;

        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = cnt_q;
                mem_wdata  = INIT_VALUE;
                data_out_d = '0;
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                mem_we = write_enable;
                if (read_enable) begin
                    data_out_d   = rd_word;
                    read_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign read_valid = read_valid_q;
    assign busy       = (state_q == ST_INIT);
    assign dbg_state  = state_q;

endmodule
